lib_lane_fifo: RTL and testbench

Parametrised multi-lane FIFO for the convolution datapath, generalising the single-, multi-write and multi-read FIFOs into one block. Each cycle it accepts 0..WR_LANES entries and releases 0..RD_LANES entries, with arbitrary (non power-of-two) DEPTH and circular wrap-around. The head lanes are exposed show-ahead. It sits between the line-buffer/window generator and the PE array, for example 3-wide row writes feeding 9-wide window reads. Each request is all-or-nothing, and rejected requests raise a sticky error flag.

---
 rtl/lib_lane_fifo_if.sv | 34 +++
 rtl/lib_lane_fifo.sv | 89 ++++++++
 tb/tb_lib_lane_fifo.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lib_lane_fifo_if.sv
// Handshake bundle for lib_lane_fifo: multi-lane enqueue/dequeue requests and show-ahead head lanes.
// master drives the requests; slave is the FIFO side.
interface lib_lane_fifo_if #(
  parameter int unsigned DEPTH    = 9,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned WR_LANES = 3,
  parameter int unsigned RD_LANES = 9
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned NW = $clog2(WR_LANES + 1);
  localparam int unsigned NR = $clog2(RD_LANES + 1);

  logic [NW-1:0]                     i_enq_num;
  logic [WR_LANES-1:0][WIDTH-1:0]    i_data;
  logic [NR-1:0]                     i_deq_num;
  logic [RD_LANES-1:0][WIDTH-1:0]    o_data;
  logic                              o_enq_ok;
  logic                              o_deq_ok;
  logic [CW-1:0]                     o_count;
  logic                              o_empty;
  logic                              o_full;
  logic                              o_afull;
  logic                              o_err;

  modport master (
    output i_enq_num, i_data, i_deq_num,
    input  o_data, o_enq_ok, o_deq_ok, o_count, o_empty, o_full, o_afull, o_err
  );

  modport slave (
    input  i_enq_num, i_data, i_deq_num,
    output o_data, o_enq_ok, o_deq_ok, o_count, o_empty, o_full, o_afull, o_err
  );
endinterface

// File: rtl/lib_lane_fifo.sv
// Multi-lane circular FIFO: up to WR_LANES writes and RD_LANES reads per cycle, any DEPTH,
// all-or-nothing grants on pre-edge occupancy, show-ahead head lanes, sticky error flag.
module lib_lane_fifo #(
  parameter int unsigned DEPTH    = 9,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned WR_LANES = 3,
  parameter int unsigned RD_LANES = 9,
  parameter int unsigned AFULL_TH = DEPTH - WR_LANES
) (
  input  logic           i_clk,
  input  logic           i_rst,
  lib_lane_fifo_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             err_q;

  logic             enq_ok;
  logic             deq_ok;
  int unsigned      enq_n;
  int unsigned      deq_n;
  int unsigned      cnt;

  // Operands never exceed 2*DEPTH-1, so one conditional subtract wraps correctly.
  function automatic logic [AW-1:0] wrap(input int unsigned p);
    return (p >= DEPTH) ? AW'(p - DEPTH) : AW'(p);
  endfunction

  always_comb begin
    enq_n  = 32'(bus.i_enq_num);
    deq_n  = 32'(bus.i_deq_num);
    cnt    = 32'(count_q);
    // Grants see only pre-edge occupancy: a same-cycle pop never makes room for a push.
    enq_ok = (enq_n <= WR_LANES) && (enq_n <= DEPTH - cnt);
    deq_ok = (deq_n <= RD_LANES) && (deq_n <= cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (enq_ok) begin
        for (int unsigned j = 0; j < WR_LANES; j++) begin
          if (j < enq_n) begin
            mem_q[wrap(32'(wr_ptr_q) + j)] <= bus.i_data[j];
          end
        end
        wr_ptr_q <= wrap(32'(wr_ptr_q) + enq_n);
      end
      if (deq_ok) begin
        rd_ptr_q <= wrap(32'(rd_ptr_q) + deq_n);
      end
      count_q <= CW'(cnt + (enq_ok ? enq_n : 32'd0) - (deq_ok ? deq_n : 32'd0));
      if ((!enq_ok && enq_n != 0) || (!deq_ok && deq_n != 0)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.o_data = '0;
    // Lanes beyond the occupancy read as zero, hiding stale contents.
    for (int unsigned k = 0; k < RD_LANES; k++) begin
      if (k < cnt) begin
        bus.o_data[k] = mem_q[wrap(32'(rd_ptr_q) + k)];
      end
    end
  end

  assign bus.o_enq_ok = enq_ok;
  assign bus.o_deq_ok = deq_ok;
  assign bus.o_count  = count_q;
  assign bus.o_empty  = (cnt == 0);
  assign bus.o_full   = (cnt == DEPTH);
  assign bus.o_afull  = (cnt >= AFULL_TH);
  assign bus.o_err    = err_q;

endmodule

// File: tb/tb_lib_lane_fifo.sv
// Directed bench for lib_lane_fifo (DEPTH=9, 3-in/9-out) with a queue scoreboard of stored entries.
module tb_lib_lane_fifo;
  localparam int unsigned DEPTH = 9;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned WRL   = 3;
  localparam int unsigned RDL   = 9;
  localparam int unsigned AFTH  = DEPTH - WRL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lib_lane_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .WR_LANES(WRL), .RD_LANES(RDL)) bus ();

  lib_lane_fifo #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .WR_LANES(WRL), .RD_LANES(RDL), .AFULL_TH(AFTH)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  logic [7:0] q[$];
  bit         m_err;
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_enq_num = '0;
    bus.i_deq_num = '0;
    bus.i_data    = '0;
  endtask

  task automatic check_state(input string tag);
    logic [71:0] exp_data;
    int c;
    exp_data = '0;
    c = q.size();
    for (int k = 0; k < RDL; k++) if (k < c) exp_data[k*8 +: 8] = q[k];
    chk({tag, " data"},  bus.o_data,  exp_data);
    chk({tag, " count"}, bus.o_count, c);
    chk({tag, " empty"}, bus.o_empty, c == 0);
    chk({tag, " full"},  bus.o_full,  c == DEPTH);
    chk({tag, " afull"}, bus.o_afull, c >= AFTH);
    chk({tag, " err"},   bus.o_err,   m_err);
  endtask

  // One cycle: drive request, check grants and show-ahead data, clock, update model, recheck.
  task automatic step(input string tag, input int en, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input int dn);
    bit eok, dok;
    bus.i_enq_num = 2'(en);
    bus.i_data    = {d2, d1, d0};
    bus.i_deq_num = 4'(dn);
    #1;
    eok = (en <= WRL) && (en <= DEPTH - q.size());
    dok = (dn <= RDL) && (dn <= q.size());
    chk({tag, " enq_ok"}, bus.o_enq_ok, eok);
    chk({tag, " deq_ok"}, bus.o_deq_ok, dok);
    check_state({tag, " pre"});
    @(posedge clk);
    if (dok) repeat (dn) q.delete(0);
    if (eok) begin
      if (en > 0) q.push_back(d0);
      if (en > 1) q.push_back(d1);
      if (en > 2) q.push_back(d2);
    end
    if ((!eok && en != 0) || (!dok && dn != 0)) m_err = 1'b1;
    #1;
    idle();
    check_state({tag, " post"});
  endtask

  task automatic do_reset(input string tag, input int en);
    rst           = 1'b1;
    bus.i_enq_num = 2'(en);
    bus.i_data    = {8'hEE, 8'hDD, 8'hCC};
    bus.i_deq_num = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    q.delete();
    m_err = 1'b0;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    m_err = 1'b0;
    do_reset("reset", 0);

    // Fill with 1..9, then drain in one 9-wide read.
    step("fill0", 3, 8'h01, 8'h02, 8'h03, 0);
    step("fill1", 3, 8'h04, 8'h05, 8'h06, 0);
    step("fill2", 3, 8'h07, 8'h08, 8'h09, 0);
    step("drain9", 0, 8'h00, 8'h00, 8'h00, 9);

    // Overflow on a full FIFO: rejected, contents kept, sticky error.
    step("refill0", 3, 8'h11, 8'h12, 8'h13, 0);
    step("refill1", 3, 8'h14, 8'h15, 8'h16, 0);
    step("refill2", 3, 8'h17, 8'h18, 8'h19, 0);
    step("ovf", 1, 8'h55, 8'h00, 8'h00, 0);
    step("sticky", 0, 8'h00, 8'h00, 8'h00, 0);
    do_reset("rst_clr", 0);

    // Wrap-around: enq 1..9, deq 4, enq A,B,C.
    step("w0", 3, 8'h01, 8'h02, 8'h03, 0);
    step("w1", 3, 8'h04, 8'h05, 8'h06, 0);
    step("w2", 3, 8'h07, 8'h08, 8'h09, 0);
    step("wdeq4", 0, 8'h00, 8'h00, 8'h00, 4);
    step("wenq", 3, 8'h0A, 8'h0B, 8'h0C, 0);
    // Count 8: pop granted, push rejected on pre-edge free space of 1.
    step("nopass", 3, 8'h21, 8'h22, 8'h23, 3);

    // Count 2 with simultaneous push 3 / pop 2.
    do_reset("rst2", 0);
    step("c2", 2, 8'h31, 8'h32, 8'h00, 0);
    step("simul", 3, 8'h41, 8'h42, 8'h43, 2);

    // Illegal lane count and underflow.
    step("deq10", 0, 8'h00, 8'h00, 8'h00, 10);
    do_reset("rst3", 0);
    step("underflow", 0, 8'h00, 8'h00, 8'h00, 1);

    // Reset beats a concurrent enqueue at count 7.
    do_reset("rst4", 0);
    step("r0", 3, 8'h51, 8'h52, 8'h53, 0);
    step("r1", 3, 8'h54, 8'h55, 8'h56, 0);
    step("r2", 1, 8'h57, 8'h00, 8'h00, 0);
    do_reset("rst_mid", 3);

    // Sustained 3-in / 3-out streaming across many wraps.
    for (int i = 0; i < 12; i++) begin
      step("stream", 3, 8'($urandom), 8'($urandom), 8'($urandom), (i == 0) ? 0 : 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
